// File: rtl/uart_rx_depacketizer.sv
// uart_rx_depacketizer: oversampling UART receiver (8N1) feeding a small receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_depacketizer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [NW-1:0] DEPTH_C = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q;
    logic [1:0]      sync_q;
    logic            rx_prev_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic            frame_err_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]   count_q, count_d;
    logic            full_q, empty_q, overrun_q, valid_q;
    logic [7:0]      data_q;
    logic            rx, stop_hit, good, push, pop;

    assign rx = sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rx_in};
            rx_prev_q   <= rx;
            frame_err_q <= 1'b0;
            cnt_q       <= cnt_q + CW'(1);
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx) state_q <= START;
                end
                START: if (cnt_q == HALF_BIT) begin
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    state_q <= rx ? IDLE : DATA;
                end
                DATA: if (cnt_q == FULL_BIT) begin
                    cnt_q   <= '0;
                    shift_q <= {rx, shift_q[7:1]};
                    idx_q   <= idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_q <= PARITY;
`else
                    if (idx_q == 3'd7) state_q <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (cnt_q == FULL_BIT) begin
                    cnt_q   <= '0;
                    state_q <= STOP;
                end
`endif
                STOP: if (cnt_q == FULL_BIT) begin
                    cnt_q       <= '0;
                    frame_err_q <= !rx;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, parity_err_q;
    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            if (state_q == PARITY && cnt_q == FULL_BIT) begin
                par_bad_q    <= ^shift_q ^ rx;
                parity_err_q <= ^shift_q ^ rx;
            end
        end
    end
    assign good       = stop_hit && rx && !par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign good       = stop_hit && rx;
    assign parity_err = 1'b0;
`endif

    assign stop_hit = state_q == STOP && cnt_q == FULL_BIT;
    assign pop      = rd_en && count_q != '0;
    // A full FIFO still accepts a byte when a read frees a slot in the same cycle.
    assign push     = good && (count_q != DEPTH_C || rd_en);

    always_comb begin
        count_d = (push && !pop) ? count_q + NW'(1) :
                  (pop && !push) ? count_q - NW'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                data_q   <= mem_q[rd_ptr_q];
            end
            valid_q   <= pop;
            count_q   <= count_d;
            full_q    <= count_d == DEPTH_C;
            empty_q   <= count_d == '0;
            overrun_q <= (good && count_q == DEPTH_C && !rd_en) || (overrun_q && !clr_err);
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign fifo_full      = full_q;
    assign fifo_empty     = empty_q;
    assign rx_busy        = state_q != IDLE;
    assign frame_err      = frame_err_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_uart_rx_depacketizer.sv
// tb_uart_rx_depacketizer: directed vector bench for the UART receiver and its FIFO.
module tb_uart_rx_depacketizer;
    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    logic par_flip = 1'b0;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst, rx_in, rd_en, clr_err;
    logic [7:0] data_out;
    logic       data_out_valid, fifo_full, fifo_empty, rx_busy, frame_err, overrun, parity_err;
    int         n_cmp = 0, n_err = 0;
    int         ferr_cnt = 0, perr_cnt = 0;
    int         f0, p0;

    uart_rx_depacketizer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .rd_en(rd_en), .clr_err(clr_err),
        .data_out(data_out), .data_out_valid(data_out_valid), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .rx_busy(rx_busy), .frame_err(frame_err),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (parity_err) perr_cnt <= perr_cnt + 1;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       wr;
        logic       ferr;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d ^ par_flip);
`endif
        send_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string nm, input logic [7:0] exp);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk({nm, " data_out"}, 32'(data_out), 32'(exp));
        chk({nm, " valid"}, 32'(data_out_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0};
        rst = 1'b0; rx_in = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset data_out", 32'(data_out), 32'h00);
        chk("reset valid", 32'(data_out_valid), 32'd0);
        chk("reset empty", 32'(fifo_empty), 32'd1);
        chk("reset full", 32'(fifo_full), 32'd0);
        chk("reset busy", 32'(rx_busy), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);
        chk("reset parity_err", 32'(parity_err), 32'd0);
        rst = 1'b1;
        idle(4);

        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            send_frame(vecs[i].d, vecs[i].stop);
            repeat (12) @(posedge clk);
            #1;
            chk($sformatf("vec%0d empty", i), 32'(fifo_empty), 32'(!vecs[i].wr));
            chk($sformatf("vec%0d frame_err pulses", i), 32'(ferr_cnt - f0), 32'(vecs[i].ferr));
            chk($sformatf("vec%0d busy after stop", i), 32'(rx_busy), 32'd0);
            rx_in = 1'b1;
            if (vecs[i].wr) begin
                read_chk($sformatf("vec%0d read", i), vecs[i].d);
                @(posedge clk);
                #1;
                chk($sformatf("vec%0d valid drop", i), 32'(data_out_valid), 32'd0);
                chk($sformatf("vec%0d empty after read", i), 32'(fifo_empty), 32'd1);
            end
            idle(4);
        end

        f0 = ferr_cnt;
        rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("glitch busy", 32'(rx_busy), 32'd1);
        idle(12);
        chk("glitch back to idle", 32'(rx_busy), 32'd0);
        chk("glitch empty", 32'(fifo_empty), 32'd1);
        chk("glitch no frame_err", 32'(ferr_cnt - f0), 32'd0);

        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1);
            idle(4);
            if (i == 8) chk("full after 8", 32'(fifo_full), 32'd1);
            if (i == 8) chk("no overrun after 8", 32'(overrun), 32'd0);
        end
        chk("overrun after 9", 32'(overrun), 32'd1);
        chk("still full after 9", 32'(fifo_full), 32'd1);
        for (int i = 1; i <= 8; i++) read_chk($sformatf("drain%0d", i), 8'(i));
        @(posedge clk);
        #1;
        chk("empty after drain", 32'(fifo_empty), 32'd1);
        chk("overrun sticky", 32'(overrun), 32'd1);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk("empty read valid", 32'(data_out_valid), 32'd0);
        chk("empty read holds data", 32'(data_out), 32'h08);
        chk("empty read keeps empty", 32'(fifo_empty), 32'd1);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("overrun cleared", 32'(overrun), 32'd0);

        for (int i = 0; i < 8; i++) begin
            send_frame(8'h11 + 8'(i), 1'b1);
            idle(4);
        end
        chk("refill full", 32'(fifo_full), 32'd1);
        fork
            send_frame(8'h19, 1'b1);
            begin
                repeat (FRAME_BITS * CPB - 2) @(posedge clk);
                #1;
                rd_en = 1'b1;
                @(posedge clk);
                #1;
                rd_en = 1'b0;
                chk("full rd+wr data", 32'(data_out), 32'h11);
                chk("full rd+wr valid", 32'(data_out_valid), 32'd1);
            end
        join
        idle(4);
        chk("full rd+wr stays full", 32'(fifo_full), 32'd1);
        chk("full rd+wr no overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 8; i++) read_chk($sformatf("wrap%0d", i), 8'h12 + 8'(i));
        @(posedge clk);
        #1;
        chk("empty after wrap", 32'(fifo_empty), 32'd1);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("midframe reset busy", 32'(rx_busy), 32'd0);
        idle(40);
        chk("midframe reset empty", 32'(fifo_empty), 32'd1);
        send_frame(8'h12, 1'b1);
        idle(4);
        chk("post reset not empty", 32'(fifo_empty), 32'd0);
        read_chk("post reset read", 8'h12);
        @(posedge clk);
        #1;
        chk("post reset only one", 32'(fifo_empty), 32'd1);

`ifdef UART_RX_PARITY_EN
        p0 = perr_cnt;
        f0 = ferr_cnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        idle(4);
        chk("bad parity pulse", 32'(perr_cnt - p0), 32'd1);
        chk("bad parity no write", 32'(fifo_empty), 32'd1);
        chk("bad parity no frame_err", 32'(ferr_cnt - f0), 32'd0);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        idle(4);
        chk("good parity no pulse", 32'(perr_cnt - p0), 32'd1);
        chk("good parity write", 32'(fifo_empty), 32'd0);
        read_chk("good parity read", 8'h07);
`else
        p0 = perr_cnt;
        chk("parity_err tied low", 32'(p0), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
